// File: rtl/dm_ctrl_if.sv
// Request/response port between the MEM stage (master) and dm_ctrl (slave).
interface dm_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_ctrl.sv
// dm_ctrl: data-memory access controller. Loads read a full word and extract
// and extend it; sub-word stores use read-modify-write.
// Optional macro DM_CTRL_MISALIGN_CHK_EN: flag misaligned half/word accesses
// as errors instead of forcing the low address bits to lane alignment.
module dm_ctrl #(
  parameter int unsigned DM_AW     = 7,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rstn,
  dm_ctrl_if.slave         req,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [3:0]       dm_loadsel,
  output logic [1:0]       dm_byte,
  input  logic [31:0]      dm_rdata
);

  localparam int unsigned AW = DM_AW + 2;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            hs_c;
  logic            err_in_c;
  logic [AW-1:0]   addr_in_c;
  logic            unused_addr_c;

  // Select and sign/zero-extend the addressed lane of a read word.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic uns, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Overlay sub-word store data onto the word read from memory.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] m;
    m = w;
    if (sz == SZ_BYTE) m[{lane, 3'b000} +: 8] = d[7:0];
    else if (lane[1])  m[31:16] = d[15:0];
    else               m[15:0]  = d[15:0];
    return m;
  endfunction

  assign hs_c          = req.req_valid && (state_q == S_IDLE);
  assign unused_addr_c = ^req.req_addr[31:AW];

  // Classify the incoming request and align its lane bits.
  always_comb begin
    addr_in_c = req.req_addr[AW-1:0];
    err_in_c  = (req.req_size == SZ_RSVD);
`ifdef DM_CTRL_MISALIGN_CHK_EN
    if ((req.req_size == SZ_HALF) && addr_in_c[0])            err_in_c = 1'b1;
    if ((req.req_size == SZ_WORD) && (addr_in_c[1:0] != 2'b00)) err_in_c = 1'b1;
`else
    if (req.req_size == SZ_HALF) addr_in_c[0]   = 1'b0;
    if (req.req_size == SZ_WORD) addr_in_c[1:0] = 2'b00;
`endif
  end

  // State register; reset aborts any sequence and drops dm_we at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (hs_c) begin
          if (err_in_c)                  state_d = S_RESP;
          else if (!req.req_we)          state_d = S_LOAD;
          else if (req.req_size == SZ_WORD) state_d = S_WRITE;
          else                           state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register and datapath registers only.
  always_comb begin
    req.req_ready  = (state_q == S_IDLE);
    req.resp_valid = (state_q == S_RESP);
    req.resp_rdata = rdata_q;
    req.resp_err   = err_q;
    dm_we          = (state_q == S_WRITE);
    dm_addr        = addr_q[AW-1:2];
    dm_wdata       = word_q;
    dm_loadsel     = 4'b0000;
    dm_byte        = 2'b00;
  end

  // Datapath next values: capture, load extraction, merge, response.
  always_comb begin
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (hs_c) begin
          size_d = req.req_size;
          uns_d  = req.req_unsigned;
          addr_d = addr_in_c;
          word_d = req.req_wdata;
          if (err_in_c) begin
            rdata_d = ERR_RDATA;
            err_d   = 1'b1;
          end
        end
      end
      S_LOAD: begin
        rdata_d = extract(dm_rdata, size_q, uns_q, addr_q[1:0]);
        err_d   = 1'b0;
      end
      S_RMW_RD: word_d = merge(dm_rdata, word_q, size_q, addr_q[1:0]);
      S_WRITE: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl with a 128-word behavioural data memory.
module tb_dm_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        dm_we;
  logic [6:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [3:0]  dm_loadsel;
  logic [1:0]  dm_byte;
  logic [31:0] mem [128];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] b_addr [3];
  logic [1:0]  b_size [3];
  logic        b_uns  [3];
  logic [31:0] b_exp  [3];
  logic [31:0] b_rd   [3];
  int          b_acc  [3];

  always #5 clk = ~clk;

  dm_ctrl_if bus ();

  dm_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (bus),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_loadsel (dm_loadsel),
    .dm_byte    (dm_byte),
    .dm_rdata   (dm_rdata)
  );

  assign dm_rdata = mem[dm_addr];

  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; measures latency from handshake edge to resp_valid and logs writes.
  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                     input int exp_wes, input logic [6:0] exp_addr, input logic [31:0] exp_wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    int wes;
    logic [31:0] wd_seen;
    @(negedge clk);
    check({tag, ":ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; wes = 0; wd_seen = 32'h0;
    while (!bus.resp_valid && lat < 10) begin
      if (dm_we) begin wes++; wd_seen = dm_wdata; end
      @(posedge clk); #1;
      lat++;
    end
    if (dm_we) wes++;
    check({tag, ":lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ":we_pulses"}, 32'(wes), 32'(exp_wes));
    if (exp_wes > 0) check({tag, ":wdata"}, wd_seen, exp_wdata);
    check({tag, ":addr"}, 32'(dm_addr), 32'(exp_addr));
    check({tag, ":err"}, 32'(bus.resp_err), 32'(exp_err));
    check({tag, ":rdata"}, bus.resp_rdata, exp_rdata);
    @(posedge clk); #1;
    check({tag, ":pulse_end"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    int cnt;
    int n_acc;
    int n_resp;
    int stalls;
    int cyc;
    logic acc;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    // Reset values
    #1;
    check("rst:dm_we", 32'(dm_we), 32'd0);
    check("rst:resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    check("rst:ready", 32'(bus.req_ready), 32'd1);
    check("rst:err", 32'(bus.resp_err), 32'd0);
    check("rst:rdata", bus.resp_rdata, 32'h0);
    check("rst:dm_addr", 32'(dm_addr), 32'h0);
    check("rst:dm_wdata", dm_wdata, 32'h0);
    check("rst:loadsel", 32'(dm_loadsel), 32'h0);
    check("rst:byte", 32'(dm_byte), 32'h0);

    // Word store then sub-word loads
    txn("sw10",  1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1, 7'd4, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("lb13",  1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 2, 0, 7'd4, 32'h0, 32'hFFFFFFDE, 1'b0);
    txn("lbu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 0, 7'd4, 32'h0, 32'h000000AD, 1'b0);
    txn("lh10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 0, 7'd4, 32'h0, 32'hFFFFBEEF, 1'b0);
    txn("lhu12", 1'b0, 2'b10, 1'b1, 32'h12, 32'h0, 2, 0, 7'd4, 32'h0, 32'h0000DEAD, 1'b0);
    txn("lw10u", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, 0, 7'd4, 32'h0, 32'hDEADBEEF, 1'b0);

    // Read-modify-write stores
    txn("sb11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h00000055, 3, 1, 7'd4, 32'hDEAD55EF, 32'h0, 1'b0);
    txn("sh12", 1'b1, 2'b10, 1'b0, 32'h12, 32'h00001234, 3, 1, 7'd4, 32'h123455EF, 32'h0, 1'b0);
    txn("lw10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2, 0, 7'd4, 32'h0, 32'h123455EF, 1'b0);
    txn("lb10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 0, 7'd4, 32'h0, 32'hFFFFFFEF, 1'b0);

    // Upper address bits alias
    txn("alias", 1'b0, 2'b00, 1'b0, 32'h210, 32'h0, 2, 0, 7'd4, 32'h0, 32'h123455EF, 1'b0);

    // Reserved size and misalignment
    txn("rsvd", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 0, 7'd4, 32'h0, 32'h0, 1'b1);
    txn("rsvd_st", 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 1, 0, 7'd4, 32'h0, 32'h0, 1'b1);
`ifdef DM_CTRL_MISALIGN_CHK_EN
    txn("lw11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1, 0, 7'd4, 32'h0, 32'h0, 1'b1);
    txn("lh13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1, 0, 7'd4, 32'h0, 32'h0, 1'b1);
    txn("sw11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAAAA, 1, 0, 7'd4, 32'h0, 32'h0, 1'b1);
`else
    txn("lw11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 0, 7'd4, 32'h0, 32'h123455EF, 1'b0);
    txn("lh13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 2, 0, 7'd4, 32'h0, 32'h00001234, 1'b0);
`endif
    check("mem4", mem[4], 32'h123455EF);

    // Reset during RMW_RD of a byte store
    txn("sw20", 1'b1, 2'b00, 1'b0, 32'h20, 32'hCAFEF00D, 2, 1, 7'd8, 32'hCAFEF00D, 32'h0, 1'b0);
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'b01; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h11; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("abort:ready_in_rmw", 32'(bus.req_ready), 32'd0);
    #1 rstn = 1'b0;
    #1;
    check("abort:ready_async", 32'(bus.req_ready), 32'd1);
    cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (dm_we || bus.resp_valid) cnt++;
    end
    @(negedge clk); rstn = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (dm_we || bus.resp_valid) cnt++;
    end
    check("abort:no_activity", 32'(cnt), 32'd0);
    check("abort:mem8", mem[8], 32'hCAFEF00D);
    check("abort:ready", 32'(bus.req_ready), 32'd1);
    check("abort:rdata", bus.resp_rdata, 32'h0);
    check("abort:dm_wdata", dm_wdata, 32'h0);

    // Back-to-back loads with req_valid held high
    b_addr[0] = 32'h10; b_size[0] = 2'b00; b_uns[0] = 1'b0; b_exp[0] = 32'h123455EF;
    b_addr[1] = 32'h20; b_size[1] = 2'b01; b_uns[1] = 1'b0; b_exp[1] = 32'h0000000D;
    b_addr[2] = 32'h22; b_size[2] = 2'b10; b_uns[2] = 1'b1; b_exp[2] = 32'h0000CAFE;
    n_acc = 0; n_resp = 0; stalls = 0; cyc = 0;
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_size = b_size[0]; bus.req_unsigned = b_uns[0];
    bus.req_addr = b_addr[0]; bus.req_valid = 1'b1;
    while (n_resp < 3 && cyc < 30) begin
      if (bus.resp_valid) begin b_rd[n_resp] = bus.resp_rdata; n_resp++; end
      acc = bus.req_ready;
      if (!acc && bus.req_valid) stalls++;
      @(posedge clk); #1;
      if (acc && bus.req_valid && n_acc < 3) begin
        b_acc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) begin
          bus.req_size = b_size[n_acc]; bus.req_unsigned = b_uns[n_acc];
          bus.req_addr = b_addr[n_acc];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      cyc++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b:accepts", 32'(n_acc), 32'd3);
    check("b2b:resps", 32'(n_resp), 32'd3);
    check("b2b:stalls", 32'(stalls), 32'd4);
    if (n_acc == 3) begin
      check("b2b:gap01", 32'(b_acc[1] - b_acc[0]), 32'd3);
      check("b2b:gap12", 32'(b_acc[2] - b_acc[1]), 32'd3);
    end
    if (n_resp == 3) begin
      check("b2b:rd0", b_rd[0], b_exp[0]);
      check("b2b:rd1", b_rd[1], b_exp[1]);
      check("b2b:rd2", b_rd[2], b_exp[2]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
